// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared activation encodings and layer scheduler state encoding
package neuron_pkg;

    typedef enum logic [1:0] {
        ACT_IDENTITY = 2'b00,
        ACT_RELU     = 2'b01,
        ACT_LEAKY    = 2'b10,
        ACT_CLAMP    = 2'b11
    } act_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_COLLECT = 3'd4,
        ST_DONE    = 3'd5
    } sched_state_e;

    // Neuron index width; a single-neuron layer still gets a 1-bit address.
    function automatic int nl_addr_width(input int num_neurons);
        return (num_neurons <= 1) ? 1 : $clog2(num_neurons);
    endfunction

endpackage

// File: rtl/neuron_layer_sched.sv
// rtl/neuron_layer_sched.sv - sequences one layer of neurons through a shared engine (optional NEURON_LAYER_SCHED_PERF_EN adds perf_cycles)
module neuron_layer_sched
    import neuron_pkg::*;
#(
    parameter int NUM_NEURONS = 4,
    parameter int NUM_INPUTS  = 8,
    parameter int X_W         = 8,
    parameter int W_W         = 8,
    parameter int B_W         = 32,
    parameter int OUT_W       = 16,
    localparam int AW         = nl_addr_width(NUM_NEURONS)
) (
    input  logic                         clk,
    input  logic                         rst_n,

    input  logic                         start,
    output logic                         in_ready,
    output logic                         busy,
    input  logic [NUM_INPUTS*X_W-1:0]    x_flat,
    input  logic [NUM_INPUTS-1:0]        mask_flat,
    input  logic [1:0]                   act_sel,

    output logic                         wmem_rd,
    output logic [AW-1:0]                wmem_addr,
    input  logic [NUM_INPUTS*W_W-1:0]    wmem_w,
    input  logic [B_W-1:0]               wmem_b,

    output logic                         ne_in_valid,
    input  logic                         ne_in_ready,
    output logic [NUM_INPUTS*X_W-1:0]    ne_x_flat,
    output logic [NUM_INPUTS*W_W-1:0]    ne_w_flat,
    output logic [B_W-1:0]               ne_bias,
    output logic [NUM_INPUTS-1:0]        ne_mask_flat,
    output logic [1:0]                   ne_act_sel,

    input  logic                         ne_out_valid,
    output logic                         ne_out_ready,
    input  logic signed [OUT_W-1:0]      ne_out_data,

    output logic                         layer_valid,
    input  logic                         layer_ready,
    output logic [NUM_NEURONS*OUT_W-1:0] layer_data
`ifdef NEURON_LAYER_SCHED_PERF_EN
    ,
    output logic [31:0]                  perf_cycles
`endif
);

    localparam logic [AW-1:0] LAST_N = AW'(NUM_NEURONS - 1);

    sched_state_e  state;
    sched_state_e  state_nxt;
    logic [AW-1:0] n;

    assign wmem_addr = n;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state strobes; ne_out_ready only while collecting
    always_comb begin
        state_nxt    = state;
        in_ready     = 1'b0;
        busy         = 1'b1;
        wmem_rd      = 1'b0;
        ne_out_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (start) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                wmem_rd   = 1'b1;
                state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (ne_in_ready) begin
                    state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                ne_out_ready = 1'b1;
                if (ne_out_valid) begin
                    state_nxt = (n == LAST_N) ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                if (layer_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand latching, engine request valid and neuron index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n            <= '0;
            ne_x_flat    <= '0;
            ne_mask_flat <= '0;
            ne_act_sel   <= '0;
            ne_w_flat    <= '0;
            ne_bias      <= '0;
            ne_in_valid  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ne_x_flat    <= x_flat;
                        ne_mask_flat <= mask_flat;
                        ne_act_sel   <= act_sel;
                        n            <= '0;
                    end
                end
                ST_LOAD: begin
                    ne_w_flat   <= wmem_w;
                    ne_bias     <= wmem_b;
                    ne_in_valid <= 1'b1;
                end
                ST_ISSUE: begin
                    if (ne_in_ready) begin
                        ne_in_valid <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (ne_out_valid && (n != LAST_N)) begin
                        n <= n + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result slots and layer_valid; results are held until the next layer overwrites them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_data  <= '0;
            layer_valid <= 1'b0;
        end else begin
            if ((state == ST_COLLECT) && ne_out_valid) begin
                for (int i = 0; i < NUM_NEURONS; i++) begin
                    if (n == AW'(i)) begin
                        layer_data[i*OUT_W +: OUT_W] <= ne_out_data;
                    end
                end
                if (n == LAST_N) begin
                    layer_valid <= 1'b1;
                end
            end
            if ((state == ST_DONE) && layer_ready) begin
                layer_valid <= 1'b0;
            end
        end
    end

`ifdef NEURON_LAYER_SCHED_PERF_EN
    // Cycles from start acceptance until layer_valid rises; frozen through DONE and IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
        end else if ((state == ST_IDLE) && start) begin
            perf_cycles <= '0;
        end else if ((state != ST_IDLE) && (state != ST_DONE) && (perf_cycles != 32'hFFFF_FFFF)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_neuron_layer_sched.sv
// tb/tb_neuron_layer_sched.sv - randomized self-checking bench with engine and weight-memory models
module tb_neuron_layer_sched;

    localparam int NN = 4;
    localparam int NI = 8;
    localparam int XW = 8;
    localparam int WW = 8;
    localparam int BW = 32;
    localparam int OW = 16;
    localparam int AW = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 in_ready;
    logic                 busy;
    logic [NI*XW-1:0]     x_flat = '0;
    logic [NI-1:0]        mask_flat = '0;
    logic [1:0]           act_sel = '0;
    logic                 wmem_rd;
    logic [AW-1:0]        wmem_addr;
    logic [NI*WW-1:0]     wmem_w = '0;
    logic [BW-1:0]        wmem_b = '0;
    logic                 ne_in_valid;
    logic                 ne_in_ready = 1'b0;
    logic [NI*XW-1:0]     ne_x_flat;
    logic [NI*WW-1:0]     ne_w_flat;
    logic [BW-1:0]        ne_bias;
    logic [NI-1:0]        ne_mask_flat;
    logic [1:0]           ne_act_sel;
    logic                 ne_out_valid = 1'b0;
    logic                 ne_out_ready;
    logic signed [OW-1:0] ne_out_data = '0;
    logic                 layer_valid;
    logic                 layer_ready = 1'b0;
    logic [NN*OW-1:0]     layer_data;
`ifdef NEURON_LAYER_SCHED_PERF_EN
    logic [31:0]          perf_cycles;
`endif

    neuron_layer_sched #(
        .NUM_NEURONS(NN), .NUM_INPUTS(NI), .X_W(XW), .W_W(WW), .B_W(BW), .OUT_W(OW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .start(start), .in_ready(in_ready), .busy(busy),
        .x_flat(x_flat), .mask_flat(mask_flat), .act_sel(act_sel),
        .wmem_rd(wmem_rd), .wmem_addr(wmem_addr), .wmem_w(wmem_w), .wmem_b(wmem_b),
        .ne_in_valid(ne_in_valid), .ne_in_ready(ne_in_ready),
        .ne_x_flat(ne_x_flat), .ne_w_flat(ne_w_flat), .ne_bias(ne_bias),
        .ne_mask_flat(ne_mask_flat), .ne_act_sel(ne_act_sel),
        .ne_out_valid(ne_out_valid), .ne_out_ready(ne_out_ready), .ne_out_data(ne_out_data),
        .layer_valid(layer_valid), .layer_ready(layer_ready), .layer_data(layer_data)
`ifdef NEURON_LAYER_SCHED_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference state
    logic [NI*WW-1:0] w_arr [NN];
    logic [BW-1:0]    b_arr [NN];
    logic [NI*XW-1:0] x_ref;
    logic [NI-1:0]    mask_ref;
    logic [1:0]       act_ref;
    int               ready_delay_n [NN];
    int               eng_lat = 0;
    int               op_idx = 0;
    int               op_count [NN];
    int               rd_addr_q [$];
    int               lv_rises = 0;
    bit               glitch_en = 1'b0;

    function automatic logic [15:0] eng_fn(input logic [63:0] w, input logic [31:0] b,
                                           input logic [63:0] x, input logic [7:0] m,
                                           input logic [1:0] a);
        return b[15:0] ^ w[15:0] ^ x[63:48] ^ {m, 6'b0, a};
    endfunction

    // weight memory: data for a read strobe appears in the following cycle, junk otherwise
    bit            rd_pend = 1'b0;
    int            rd_addr = 0;
    bit            prev_rd = 1'b0;
    always @(negedge clk) begin
        if (rd_pend) begin
            wmem_w = w_arr[rd_addr];
            wmem_b = b_arr[rd_addr];
        end else begin
            wmem_w = {$urandom, $urandom};
            wmem_b = $urandom;
        end
        rd_pend = wmem_rd && rst_n;
        rd_addr = int'(wmem_addr);
        if (wmem_rd && rst_n) begin
            rd_addr_q.push_back(int'(wmem_addr));
            check("wmem_rd_one_cycle", 64'(prev_rd), 64'd0);
        end
        prev_rd = wmem_rd;
    end

    // layer_valid rise counter
    bit lv_prev = 1'b0;
    always @(negedge clk) begin
        if (layer_valid && !lv_prev) lv_rises++;
        lv_prev = layer_valid;
    end

    // engine model: configurable accept delay and result latency, optional stray out_valid pulses
    bit               eng_busy = 1'b0;
    bit               out_fire = 1'b0;
    bit               glitch_on = 1'b0;
    bit               in_hold = 1'b0;
    int               in_wait = 0;
    int               out_wait = 0;
    logic [15:0]      eng_res = '0;
    logic [NI*WW-1:0] snap_w;
    logic [BW-1:0]    snap_b;
    logic [NI*XW-1:0] snap_x;
    always @(negedge clk) begin
        if (!rst_n) begin
            ne_in_ready  = 1'b0;
            ne_out_valid = 1'b0;
            eng_busy     = 1'b0;
            out_fire     = 1'b0;
            glitch_on    = 1'b0;
            in_hold      = 1'b0;
            in_wait      = 0;
        end else begin
            if (out_fire) begin
                ne_out_valid = 1'b0;
                eng_busy     = 1'b0;
                out_fire     = 1'b0;
            end
            if (glitch_on) begin
                ne_out_valid = 1'b0;
                glitch_on    = 1'b0;
            end
            if (eng_busy && !ne_out_valid) begin
                if (out_wait == 0) begin
                    ne_out_valid = 1'b1;
                    ne_out_data  = eng_res;
                end else begin
                    out_wait--;
                end
            end else if (!eng_busy && glitch_en && !ne_out_ready && ($urandom_range(0, 2) == 0)) begin
                ne_out_valid = 1'b1;
                ne_out_data  = 16'($urandom);
                glitch_on    = 1'b1;
            end
            if (ne_out_valid && ne_out_ready && !glitch_on) out_fire = 1'b1;

            ne_in_ready = 1'b0;
            if (ne_in_valid && !eng_busy) begin
                if (in_hold) begin
                    check("issue_w_stable", ne_w_flat, snap_w);
                    check("issue_b_stable", 64'(ne_bias), 64'(snap_b));
                    check("issue_x_stable", ne_x_flat, snap_x);
                end else begin
                    snap_w = ne_w_flat;
                    snap_b = ne_bias;
                    snap_x = ne_x_flat;
                end
                if (in_wait >= ((op_idx < NN) ? ready_delay_n[op_idx] : 0)) begin
                    ne_in_ready = 1'b1;
                    in_wait     = 0;
                    if (op_idx < NN) begin
                        check("op_x", ne_x_flat, x_ref);
                        check("op_mask", 64'(ne_mask_flat), 64'(mask_ref));
                        check("op_act", 64'(ne_act_sel), 64'(act_ref));
                        check("op_w", ne_w_flat, w_arr[op_idx]);
                        check("op_bias", 64'(ne_bias), 64'(b_arr[op_idx]));
                        eng_res = eng_fn(ne_w_flat, ne_bias, ne_x_flat, ne_mask_flat, ne_act_sel);
                        op_count[op_idx]++;
                    end else begin
                        check("extra_engine_op", 64'(op_idx), 64'(NN - 1));
                    end
                    op_idx++;
                    eng_busy = 1'b1;
                    out_wait = eng_lat;
                end else begin
                    in_wait++;
                end
            end
            in_hold = ne_in_valid && !ne_in_ready;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_wmem_rd"}, 64'(wmem_rd), 64'd0);
        check({tag, "_wmem_addr"}, 64'(wmem_addr), 64'd0);
        check({tag, "_ne_in_valid"}, 64'(ne_in_valid), 64'd0);
        check({tag, "_ne_out_ready"}, 64'(ne_out_ready), 64'd0);
        check({tag, "_layer_valid"}, 64'(layer_valid), 64'd0);
        check({tag, "_layer_data"}, layer_data, 64'd0);
        check({tag, "_ne_x"}, ne_x_flat, 64'd0);
        check({tag, "_ne_w"}, ne_w_flat, 64'd0);
        check({tag, "_ne_bias"}, 64'(ne_bias), 64'd0);
        check({tag, "_ne_mask_act"}, 64'({ne_mask_flat, ne_act_sel}), 64'd0);
`ifdef NEURON_LAYER_SCHED_PERF_EN
        check({tag, "_perf"}, 64'(perf_cycles), 64'd0);
`endif
    endtask

    // prepare model and pulse start (called at a negedge, returns one negedge later)
    task automatic begin_layer(input bit directed, input int lat, input int max_delay,
                               input int stall_n, input int stall_cyc);
        eng_lat = lat;
        op_idx  = 0;
        rd_addr_q.delete();
        for (int i = 0; i < NN; i++) begin
            op_count[i]      = 0;
            ready_delay_n[i] = $urandom_range(0, max_delay);
            if (directed) begin
                w_arr[i] = '0;
                b_arr[i] = BW'(i * 16 + 1);
            end else begin
                w_arr[i] = {$urandom, $urandom};
                b_arr[i] = $urandom;
            end
        end
        if (stall_n >= 0) ready_delay_n[stall_n] = stall_cyc;
        x_ref    = directed ? '0 : {$urandom, $urandom};
        mask_ref = directed ? '0 : NI'($urandom);
        act_ref  = directed ? 2'b00 : 2'($urandom);
        check("idle_in_ready", 64'(in_ready), 64'd1);
        x_flat    = x_ref;
        mask_flat = mask_ref;
        act_sel   = act_ref;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        x_flat    = {$urandom, $urandom};
        mask_flat = NI'($urandom);
        act_sel   = 2'($urandom);
        check("start_busy", 64'(busy), 64'd1);
    endtask

    task automatic run_layer(input bit directed, input int lat, input int max_delay,
                             input int stall_n, input int stall_cyc, input int done_hold,
                             input bit start_in_done, input bit start_with_ready);
        logic [63:0] exp_data;
        int          exp_perf;
        int          rises0;
        int          budget;
        rises0 = lv_rises;
        begin_layer(directed, lat, max_delay, stall_n, stall_cyc);
        budget = 0;
        while (!layer_valid && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        check("layer_valid_timeout", 64'(layer_valid), 64'd1);

        exp_data = '0;
        exp_perf = 0;
        for (int i = 0; i < NN; i++) begin
            exp_data[i*OW +: OW] = eng_fn(w_arr[i], b_arr[i], x_ref, mask_ref, act_ref);
            exp_perf += 4 + lat + ready_delay_n[i];
        end
        check("layer_data", layer_data, exp_data);
        if (directed) check("layer_data_const", layer_data, 64'h0031_0021_0011_0001);
        check("rd_count", 64'(rd_addr_q.size()), 64'(NN));
        for (int i = 0; i < NN && i < rd_addr_q.size(); i++) check("rd_addr_seq", 64'(rd_addr_q[i]), 64'(i));
        for (int i = 0; i < NN; i++) check("ops_per_neuron", 64'(op_count[i]), 64'd1);
`ifdef NEURON_LAYER_SCHED_PERF_EN
        check("perf_cycles", 64'(perf_cycles), 64'(exp_perf));
`endif

        for (int i = 0; i < done_hold; i++) begin
            start = start_in_done && (i % 3 == 0);
            @(negedge clk);
            check("done_valid_hold", 64'(layer_valid), 64'd1);
            check("done_data_hold", layer_data, exp_data);
            check("done_busy", 64'(busy), 64'd1);
        end
        start       = start_with_ready;
        layer_ready = 1'b1;
        @(negedge clk);
        layer_ready = 1'b0;
        start       = 1'b0;
        check("valid_falls", 64'(layer_valid), 64'd0);
        check("back_idle", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("start_not_taken", 64'(busy), 64'd0);
        check("one_valid_rise", 64'(lv_rises - rises0), 64'd1);
`ifdef NEURON_LAYER_SCHED_PERF_EN
        check("perf_held", 64'(perf_cycles), 64'(exp_perf));
`endif
    endtask

    initial begin
        int budget;
        int rises0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // directed: bias echo, zero-latency engine
        run_layer(1'b1, 0, 0, -1, 0, 0, 1'b0, 1'b0);
        glitch_en = 1'b1;
        // neuron 2 accept stalled for 5 cycles
        run_layer(1'b0, 0, 0, 2, 5, 0, 1'b0, 1'b0);
        // layer_ready held off 10 cycles with start pulses in DONE, start coincident with layer_ready
        run_layer(1'b0, 1, 0, -1, 0, 10, 1'b1, 1'b1);
        // 3-cycle engine latency, immediate handshakes
        run_layer(1'b0, 3, 0, -1, 0, 0, 1'b0, 1'b0);

        // reset in COLLECT of neuron 1
        rises0 = lv_rises;
        begin_layer(1'b0, 3, 0, -1, 0);
        budget = 0;
        while (!(ne_out_ready && op_idx == 2) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check("reach_collect_n1", 64'(ne_out_ready && op_idx == 2), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("aborted_no_valid", 64'(lv_rises - rises0), 64'd0);
        check("aborted_idle", 64'(busy), 64'd0);
        run_layer(1'b0, 0, 0, -1, 0, 0, 1'b0, 1'b0);

        // randomized layers
        for (int k = 0; k < 6; k++) begin
            run_layer(1'b0, $urandom_range(0, 4), 3, -1, 0, $urandom_range(0, 4),
                      1'b1, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
